// File: rtl/serial_alu_pkg.sv
// ============================================================================
// Module   : serial_alu_pkg
// Purpose  : Shared op-code and FSM state encodings for the bit-serial ALU.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package serial_alu_pkg;

  typedef enum logic [1:0] {
    OP_NOR = 2'b00,
    OP_XOR = 2'b01,
    OP_ADD = 2'b10,
    OP_SUB = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_e;

endpackage

`default_nettype wire

// File: rtl/serial_bit_slice.sv
// ============================================================================
// Module   : serial_bit_slice
// Purpose  : Combinational 1-bit ALU slice (NOR / XOR / ADD / SUB).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_bit_slice
  import serial_alu_pkg::*;
(
  input  logic       ai,
  input  logic       bi,
  input  logic       ci,
  input  logic [1:0] op,
  output logic       si,
  output logic       co
);

  op_e w_op;
  assign w_op = op_e'(op);

  always_comb begin
    si = 1'b0;
    co = 1'b0;
    case (w_op)
      OP_NOR: si = ~(ai | bi);
      OP_XOR: si = ai ^ bi;
      OP_ADD: begin
        si = ai ^ bi ^ ci;
        co = (ai & bi) | (ai & ci) | (bi & ci);
      end
      OP_SUB: begin
        // a + ~b + 1: the initial carry of 1 is loaded by the controller
        si = ai ^ ~bi ^ ci;
        co = (ai & ~bi) | (ai & ci) | (~bi & ci);
      end
      default: begin
        si = 1'b0;
        co = 1'b0;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/serial_alu.sv
// ============================================================================
// Module   : serial_alu
// Purpose  : Bit-serial ALU, one bit per cycle LSB first; optional signed
//            overflow output enabled by SERIAL_ALU_OVF_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_alu
  import serial_alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             zero
`ifdef SERIAL_ALU_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int c_cnt_w = $clog2(WIDTH);

  state_e             r_state;
  state_e             w_next;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [1:0]         r_op;
  logic [c_cnt_w-1:0] r_cnt;
  logic               r_carry;
  logic [WIDTH-1:0]   r_result;
  logic               r_cout;
  logic               w_si;
  logic               w_co;
  logic               w_last;

  serial_bit_slice u_slice (
    .ai (r_a[0]),
    .bi (r_b[0]),
    .ci (r_carry),
    .op (r_op),
    .si (w_si),
    .co (w_co)
  );

  assign w_last = (r_cnt == c_cnt_w'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start)  w_next = SHIFT;
      SHIFT:   if (w_last) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // r_a doubles as the result accumulator: slice output enters at the MSB
  // while operand bits leave at the LSB.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= 2'b00;
      r_cnt    <= '0;
      r_carry  <= 1'b0;
      r_result <= '0;
      r_cout   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_op    <= op;
            r_cnt   <= '0;
            r_carry <= op[1] & op[0];
          end
        end
        SHIFT: begin
          r_a     <= {w_si, r_a[WIDTH-1:1]};
          r_b     <= {1'b0, r_b[WIDTH-1:1]};
          r_carry <= w_co;
          r_cnt   <= r_cnt + c_cnt_w'(1);
          if (w_last) begin
            r_result <= {w_si, r_a[WIDTH-1:1]};
            r_cout   <= w_co;
          end
        end
        default: begin
        end
      endcase
    end
  end

`ifdef SERIAL_ALU_OVF_EN
  logic r_ovf;

  // Signed overflow: carry into the MSB differs from carry out of it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (r_state == SHIFT && w_last) begin
      r_ovf <= r_op[1] & (r_carry ^ w_co);
    end
  end

  assign ovf = r_ovf;
`endif

  assign busy   = (r_state != IDLE);
  assign done   = (r_state == DONE);
  assign result = r_result;
  assign cout   = r_cout;
  assign zero   = (r_result == '0);

endmodule

`default_nettype wire

// File: tb/tb_serial_alu.sv
// ============================================================================
// Module   : tb_serial_alu
// Purpose  : Directed self-checking bench for serial_alu (WIDTH=8); checks
//            ovf when SERIAL_ALU_OVF_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_alu;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         cout;
  logic         zero;
`ifdef SERIAL_ALU_OVF_EN
  logic         ovf;
`endif

  int checks = 0;
  int errors = 0;

  serial_alu #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .cout   (cout),
    .zero   (zero)
`ifdef SERIAL_ALU_OVF_EN
    ,
    .ovf    (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits up to 40 edges for done; returns edge count (0 on timeout).
  task automatic wait_done(output int n);
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (done === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic run_op(input string tag, input logic [1:0] t_op,
                        input logic [W-1:0] t_a, input logic [W-1:0] t_b,
                        input logic [W-1:0] e_res, input logic e_cout,
                        input logic e_zero, input logic e_ovf);
    int n;
    start = 1'b1; op = t_op; a = t_a; b = t_b;
    tick();
    start = 1'b0;
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    wait_done(n);
    chk({tag, "_latency"}, 32'(n), 32'(W));
    chk({tag, "_result"}, 32'(result), 32'(e_res));
    chk({tag, "_cout"}, 32'(cout), 32'(e_cout));
    chk({tag, "_zero"}, 32'(zero), 32'(e_zero));
`ifdef SERIAL_ALU_OVF_EN
    chk({tag, "_ovf"}, 32'(ovf), 32'(e_ovf));
`else
    if (e_ovf === 1'bx) $display("unreachable");
`endif
    tick();
    chk({tag, "_done_pulse"}, 32'(done), 32'd0);
    chk({tag, "_idle"}, 32'(busy), 32'd0);
    chk({tag, "_hold"}, 32'(result), 32'(e_res));
  endtask

  initial begin
    int n;
    int pulses;
    rst_n = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0;
    tick();
    tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    chk("rst_zero", 32'(zero), 32'd1);
`ifdef SERIAL_ALU_OVF_EN
    chk("rst_ovf", 32'(ovf), 32'd0);
`endif
    rst_n = 1'b1;
    tick();

    run_op("add7f01", 2'b10, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0, 1'b1);
    run_op("sub0505", 2'b11, 8'h05, 8'h05, 8'h00, 1'b1, 1'b1, 1'b0);
    run_op("sub0305", 2'b11, 8'h03, 8'h05, 8'hFE, 1'b0, 1'b0, 1'b0);
    run_op("norf00c", 2'b00, 8'hF0, 8'h0C, 8'h03, 1'b0, 1'b0, 1'b0);
    run_op("xorff0f", 2'b01, 8'hFF, 8'h0F, 8'hF0, 1'b0, 1'b0, 1'b0);
    run_op("addff01", 2'b10, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0);

    // Start pulsed during SHIFT cycle 3 must be ignored, not queued.
    start = 1'b1; op = 2'b10; a = 8'h10; b = 8'h20;
    tick();
    start = 1'b0;
    tick();
    tick();
    start = 1'b1; op = 2'b01; a = 8'hAA; b = 8'h00;
    tick();
    start = 1'b0;
    pulses = 0;
    for (int i = 0; i < 25; i++) begin
      if (done === 1'b1) pulses++;
      tick();
    end
    chk("ign_pulses", 32'(pulses), 32'd1);
    chk("ign_result", 32'(result), 32'h30);
    chk("ign_idle", 32'(busy), 32'd0);

    // Reset asserted for the edge ending SHIFT cycle 4.
    start = 1'b1; op = 2'b11; a = 8'h09; b = 8'h02;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_result", 32'(result), 32'd0);
    chk("abort_zero", 32'(zero), 32'd1);
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done === 1'b1) pulses++;
    end
    chk("abort_nodone", 32'(pulses), 32'd0);
    run_op("post_rst", 2'b10, 8'h12, 8'h34, 8'h46, 1'b0, 1'b0, 1'b0);

    // Start held high: restarts on the first IDLE cycle after DONE.
    start = 1'b1; op = 2'b01; a = 8'h55; b = 8'hFF;
    tick();
    wait_done(n);
    chk("hold_latency1", 32'(n), 32'(W));
    chk("hold_result1", 32'(result), 32'hAA);
    tick();
    chk("hold_idle", 32'(busy), 32'd0);
    tick();
    chk("hold_restart", 32'(busy), 32'd1);
    start = 1'b0;
    wait_done(n);
    chk("hold_latency2", 32'(n), 32'(W));
    chk("hold_result2", 32'(result), 32'hAA);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/serial_alu.md
SERIAL_ALU -- requirements
Module: serial_alu

Interface
REQ-001 Parameter WIDTH, default 8: operand and result width in bits, legal range 2..32.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 start  input  1  request a new operation; sampled only in IDLE.
REQ-005 op  input  2  operation: 00 NOR, 01 XOR, 10 ADD (a+b), 11 SUB (a-b).
REQ-006 a  input  WIDTH  operand A, captured on accepted start.
REQ-007 b  input  WIDTH  operand B, captured on accepted start.
REQ-008 busy  output  1  high while an operation is in progress (SHIFT or DONE).
REQ-009 done  output  1  one-cycle pulse; result and flags are valid from this cycle.
REQ-010 result  output  WIDTH  operation result.
REQ-011 cout  output  1  final carry of ADD/SUB; 0 for NOR/XOR.
REQ-012 zero  output  1  high when result is all zeros.

Function
REQ-013 The block SHALL have exactly three states: IDLE, SHIFT and DONE.
REQ-014 In IDLE with start=1, the block SHALL capture a, b and op, load a bit counter with 0 and the carry register with op[1]&op[0], then go to SHIFT.
REQ-015 In SHIFT, the block SHALL process one bit per cycle, LSB first, through a 1-bit slice.
- Slice operations: NOR = ~(ai|bi); XOR = ai^bi; ADD = ai^bi^c; SUB = ai^~bi^c.
- Each result bit SHALL shift into result from the MSB side.
- The slice carry SHALL be stored in the carry register for ADD/SUB and cleared for NOR/XOR.
REQ-016 SHIFT SHALL last exactly WIDTH cycles; the cycle after the last bit, the state SHALL be DONE.
REQ-017 In DONE, done SHALL be 1 for exactly one cycle, then the state SHALL return to IDLE.
- Latency: start accepted at edge N gives done high during cycle N+WIDTH+1.
REQ-018 result, cout and zero SHALL hold their values from DONE until the next accepted start.
- result SHALL not show intermediate values to the consumer: it is updated into an output register only on entry to DONE.
REQ-019 start asserted in SHIFT or DONE SHALL be ignored and SHALL NOT be queued.
REQ-020 start held high continuously SHALL begin a new operation on the first IDLE cycle after DONE.
REQ-021 SUB SHALL be two's-complement: cout=1 means no borrow (a>=b unsigned).
REQ-022 ADD overflow beyond WIDTH bits SHALL wrap; the carry appears only on cout.

Reset
REQ-023 With rst_n=0 at a rising edge, the block SHALL enter IDLE and clear busy, done, result, cout and the counter; zero SHALL read 1.
REQ-024 Reset during SHIFT or DONE SHALL abort the operation with no done pulse.
REQ-025 The first start after rst_n returns high SHALL be accepted normally.

Configuration
REQ-026 With SERIAL_ALU_OVF_EN defined, an extra output ovf (1 bit) SHALL exist.
- ovf = signed overflow of ADD/SUB, i.e. carry into MSB XOR carry out of MSB.
- ovf SHALL be 0 for NOR/XOR, 0 after reset, and held like cout.
REQ-027 With SERIAL_ALU_OVF_EN undefined, neither ovf nor its logic SHALL exist.

Structure
REQ-028 A shared package serial_alu_pkg SHALL hold:
- the op encoding typedef (OP_NOR, OP_XOR, OP_ADD, OP_SUB);
- the state typedef (IDLE, SHIFT, DONE).
REQ-029 The per-bit logic SHALL be a combinational sub-module serial_bit_slice (ai, bi, ci, op -> si, co).
- The FSM, shift registers and counter SHALL be in serial_alu.

Verification
REQ-030 The bench SHALL cover these directed scenarios with WIDTH=8:
- ADD a=0x7F, b=0x01 -> done at cycle 9 after start; result=0x80, cout=0, zero=0, ovf=1 (if enabled).
- SUB a=0x05, b=0x05 -> result=0x00, cout=1, zero=1, ovf=0.
- SUB a=0x03, b=0x05 -> result=0xFE, cout=0.
- NOR a=0xF0, b=0x0C -> result=0x03, cout=0; XOR a=0xFF, b=0x0F -> result=0xF0.
- start pulsed at cycle 3 of SHIFT -> ignored; exactly one done pulse; result unchanged until the next accepted start.
- rst_n low during SHIFT cycle 4 -> IDLE next cycle, no done, result=0, zero=1; the next start completes correctly.
